bin2bcd_seq: RTL

Sequential binary-to-BCD converter that produces the digit stream consumed by the `bcd7seg` display drivers. It takes an unsigned binary value, such as a player score, on a start pulse, and runs iterative shift-add-3 (double dabble), one bit per clock. It then presents packed BCD digits with per-digit leading-zero blanking flags that connect directly to each driver's `dis` input. It sits between the score counters and the 7-segment display bank.

---
 rtl/bin2bcd_pkg.sv | 13 +
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin2bcd_seq.sv | 97 +++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal place.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  always_comb begin
    adjusted = (digit >= BCD_W'(5)) ? digit + BCD_W'(3) : digit;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with leading-zero blanking flags and saturating overflow for the display bank.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]         blank,
  output logic                      ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = BCD_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BIN_W-1:0]  sreg;
  logic [SCR_W-1:0]  scratch;
  logic [SCR_W-1:0]  scratch_adj;
  logic              ovf_acc;
  logic [DIGITS-1:0] blank_calc;
  logic              upper_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch[g*BCD_W +: BCD_W]),
      .adjusted (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  // A digit is blank only if it and every digit above it are zero; the ones digit always shows.
  always_comb begin
    blank_calc = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (scratch[i*BCD_W +: BCD_W] == '0);
      blank_calc[i] = upper_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= BLANK_RST;
      ovf     <= 1'b0;
      cnt     <= '0;
      sreg    <= '0;
      scratch <= '0;
      ovf_acc <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= bin;
            scratch <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Any 1 pushed out of the top digit means the value needs more digits than we have.
          {scratch, sreg} <= {scratch_adj[SCR_W-2:0], sreg, 1'b0};
          ovf_acc         <= ovf_acc | scratch_adj[SCR_W-1];
          cnt             <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= ovf_acc ? {DIGITS{BCD_NINE}} : scratch;
          blank <= ovf_acc ? '0 : blank_calc;
          ovf   <= ovf_acc;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
